// File: rtl/spi_alu_sequencer.sv
// SPI mode-0 slave that receives a CMD/OPERANDS frame, drives the ALU operands and opcode,
// and shifts the captured result and flags back to the master during the third byte.
//
// state  | meaning
// IDLE   | CS released, waiting for a CS falling edge
// CMD    | receiving command byte (marker 2'b10 in bits 7:6, opcode in bits 1:0)
// OPND   | receiving operand byte (A in 7:4, B in 3:0)
// EXEC   | one cycle: ALU inputs settled, capture result and flags
// REPLY  | shifting the status byte out on MISO
// DRAIN  | frame finished or aborted, ignore SCLK until CS releases
module spi_alu_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_n,
  output logic       op_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_OPND, S_EXEC, S_REPLY, S_DRAIN
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_n_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_n_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx;
  logic [7:0]             reply;
  logic [1:0]             op_tmp;
  logic [TW-1:0]          to_cnt;

  logic       sclk_s, cs_n_s, mosi_s;
  logic       rise, fall, cs_act, cs_fall;
  logic       byte_done, timed, to_hit;
  logic [7:0] rx_nxt;

  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    rise      = sclk_s & ~sclk_prev;
    fall      = ~sclk_s & sclk_prev;
    cs_act    = ~cs_n_s;
    cs_fall   = cs_n_prev & ~cs_n_s;
    rx_nxt    = {rx[6:0], mosi_s};
    byte_done = rise && (bit_cnt == 3'd7);
    timed     = (state == S_CMD) || (state == S_OPND) || (state == S_REPLY);
    to_hit    = (TIMEOUT_CYCLES != 0) && timed && cs_act && (to_cnt == '0) && !(rise || fall);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      sclk_sync <= '0;
      cs_n_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_n_prev <= 1'b0;
      bit_cnt   <= 3'd0;
      rx        <= 8'd0;
      reply     <= 8'd0;
      op_tmp    <= 2'd0;
      to_cnt    <= '0;
      spi_miso  <= 1'b0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_op    <= 2'd0;
      op_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_n_prev <= cs_n_s;
      op_valid  <= 1'b0;

      // Down-counter reloads on any SCLK edge and whenever the frame is not in a timed state.
      if (!timed || rise || fall)
        to_cnt <= TO_LOAD;
      else if (to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;

      if (rise && cs_act && timed) begin
        rx      <= rx_nxt;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (cs_n_s) begin
        state    <= S_IDLE;
        bit_cnt  <= 3'd0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            spi_miso <= 1'b0;
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= 3'd0;
            end
          end
          S_CMD: begin
            if (to_hit) begin
              frame_err <= 1'b1;
              state     <= S_DRAIN;
            end else if (byte_done) begin
              if (rx_nxt[7:6] == 2'b10) begin
                op_tmp <= rx_nxt[1:0];
                state  <= S_OPND;
              end else begin
                frame_err <= 1'b1;
                state     <= S_DRAIN;
              end
            end
          end
          S_OPND: begin
            if (to_hit) begin
              frame_err <= 1'b1;
              state     <= S_DRAIN;
            end else if (byte_done) begin
              alu_a  <= rx_nxt[7:4];
              alu_b  <= rx_nxt[3:0];
              alu_op <= op_tmp;
              state  <= S_EXEC;
            end
          end
          S_EXEC: begin
            reply     <= {alu_z, alu_c, alu_v, alu_n, alu_result};
            op_valid  <= 1'b1;
            frame_err <= 1'b0;
            spi_miso  <= alu_z;
            state     <= S_REPLY;
          end
          S_REPLY: begin
            if (to_hit) begin
              frame_err <= 1'b1;
              spi_miso  <= 1'b0;
              state     <= S_DRAIN;
            end else if (byte_done) begin
              spi_miso <= 1'b0;
              state    <= S_DRAIN;
            end else if (fall && bit_cnt != 3'd0) begin
              // The trailing fall of the operand byte arrives with bit_cnt==0 and must not shift.
              reply    <= {reply[6:0], 1'b0};
              spi_miso <= reply[6];
            end
          end
          S_DRAIN: spi_miso <= 1'b0;
          default: begin
            state    <= S_IDLE;
            spi_miso <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
